// File: rtl/ddram_wr_responder.sv
// Gathers 16-bit toggle-handshake writes into one 64-bit DDRAM qword and writes
// it out when the qword is full, when a different qword is addressed, or on flush.
module ddram_wr_responder #(
  parameter logic [6:0] BASE = 7'h18
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic [24:0] wraddr,
  input  logic [15:0] din,
  input  logic        we_req,
  output logic        we_ack,
  input  logic        flush,
  output logic        idle,
  input  logic        DDRAM_BUSY,
  output logic [28:0] DDRAM_ADDR,
  output logic [63:0] DDRAM_DIN,
  output logic [7:0]  DDRAM_BE,
  output logic        DDRAM_WE,
  output logic [7:0]  DDRAM_BURSTCNT,
  output logic        DDRAM_RD,
  output logic        state_dbg
);

  // Handshakes: a request is pending while we_req != we_ack and is retired by
  // toggling we_ack; a DDRAM write completes on a clk_sys edge with
  // DDRAM_WE=1 and DDRAM_BUSY=0, with ADDR/DIN/BE held constant until then.
  typedef enum logic {S_IDLE = 1'b0, S_WRITE = 1'b1} state_t;

  state_t      state;
  logic [21:0] qaddr;
  logic [63:0] data;
  logic [7:0]  be;
  logic        flush_pend;
  logic        flush_wr;

  logic        pending;
  logic        valid;
  logic        same_q;
  logic        flush_now;
  logic [1:0]  lane;
  logic [21:0] wq;
  logic [7:0]  be_abs;
  logic [63:0] data_abs;
  logic        unused_bit0;

  assign pending     = (we_req != we_ack);
  assign valid       = |be;
  assign wq          = wraddr[24:3];
  assign lane        = wraddr[2:1];
  assign same_q      = (qaddr == wq);
  assign flush_now   = flush | flush_pend;
  assign unused_bit0 = wraddr[0];

  // Absorbing into an empty buffer starts from zero so unwritten lanes read 0.
  always_comb begin
    be_abs   = valid ? be : 8'h00;
    data_abs = valid ? data : 64'h0;
    be_abs[{lane, 1'b0} +: 2]    = 2'b11;
    data_abs[{lane, 4'b0} +: 16] = din;
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state      <= S_IDLE;
      DDRAM_WE   <= 1'b0;
      be         <= 8'h00;
      data       <= 64'h0;
      qaddr      <= 22'h0;
      flush_pend <= 1'b0;
      flush_wr   <= 1'b0;
      we_ack     <= we_req;
    end else begin
      case (state)
        S_IDLE: begin
          if (be == 8'hFF || (pending && valid && !same_q)) begin
            state      <= S_WRITE;
            DDRAM_WE   <= 1'b1;
            flush_wr   <= flush_now;
            flush_pend <= flush_now;
          end else if (pending) begin
            be         <= be_abs;
            data       <= data_abs;
            qaddr      <= wq;
            we_ack     <= ~we_ack;
            flush_pend <= flush_now;
          end else if (flush_now && valid) begin
            state      <= S_WRITE;
            DDRAM_WE   <= 1'b1;
            flush_wr   <= 1'b1;
            flush_pend <= 1'b1;
          end else begin
            flush_pend <= 1'b0;
          end
        end
        S_WRITE: begin
          if (!DDRAM_BUSY) begin
            state      <= S_IDLE;
            DDRAM_WE   <= 1'b0;
            be         <= 8'h00;
            flush_pend <= flush | (flush_pend & ~flush_wr);
          end else begin
            flush_pend <= flush_pend | flush;
          end
        end
        default: begin
          state    <= S_IDLE;
          DDRAM_WE <= 1'b0;
        end
      endcase
    end
  end

  assign DDRAM_ADDR     = {BASE, qaddr};
  assign DDRAM_DIN      = data;
  assign DDRAM_BE       = be;
  assign DDRAM_BURSTCNT = 8'd1;
  assign DDRAM_RD       = 1'b0;
  assign state_dbg      = (state == S_WRITE);
  assign idle           = !pending && !valid && (state == S_IDLE) && !flush_pend;

endmodule

// File: tb/tb_ddram_wr_responder.sv
// Bench for ddram_wr_responder: a qword-merging reference model feeds an
// expected-write queue that a negedge monitor drains as DDRAM writes complete.
module tb_ddram_wr_responder;

  logic        clk_sys = 1'b0;
  logic        reset = 1'b1;
  logic [24:0] wraddr = '0;
  logic [15:0] din = '0;
  logic        we_req = 1'b0;
  logic        we_ack;
  logic        flush = 1'b0;
  logic        idle;
  logic        DDRAM_BUSY = 1'b0;
  logic [28:0] DDRAM_ADDR;
  logic [63:0] DDRAM_DIN;
  logic [7:0]  DDRAM_BE;
  logic        DDRAM_WE;
  logic [7:0]  DDRAM_BURSTCNT;
  logic        DDRAM_RD;
  logic        state_dbg;

  int tests = 0;
  int fails = 0;
  int busy_mode = 0;
  logic [100:0] exp_q[$];

  logic [21:0] m_qaddr = '0;
  logic [63:0] m_data = '0;
  logic [7:0]  m_be = '0;

  ddram_wr_responder dut (
    .clk_sys(clk_sys), .reset(reset), .wraddr(wraddr), .din(din),
    .we_req(we_req), .we_ack(we_ack), .flush(flush), .idle(idle),
    .DDRAM_BUSY(DDRAM_BUSY), .DDRAM_ADDR(DDRAM_ADDR), .DDRAM_DIN(DDRAM_DIN),
    .DDRAM_BE(DDRAM_BE), .DDRAM_WE(DDRAM_WE), .DDRAM_BURSTCNT(DDRAM_BURSTCNT),
    .DDRAM_RD(DDRAM_RD), .state_dbg(state_dbg)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: drives BUSY, checks hold-under-busy, pops expected writes on completion.
  logic         prev_we = 1'b0, prev_busy = 1'b0, prev_rst = 1'b1, prev_acc = 1'b0;
  logic [100:0] prev_out = '0;
  always @(negedge clk_sys) begin
    logic [100:0] cur;
    logic [100:0] e;
    cur = {DDRAM_ADDR, DDRAM_DIN, DDRAM_BE};
    if (prev_acc && !prev_rst) check("we_drop_after_accept", DDRAM_WE, 1'b0);
    if (prev_we && prev_busy && !prev_rst) begin
      check("we_held_busy", DDRAM_WE, 1'b1);
      check("out_stable_busy", cur, prev_out);
    end
    case (busy_mode)
      0:       DDRAM_BUSY = 1'b0;
      1:       DDRAM_BUSY = ($urandom_range(0, 2) == 0);
      default: DDRAM_BUSY = 1'b1;
    endcase
    prev_acc = 1'b0;
    if (DDRAM_WE && !DDRAM_BUSY && !reset) begin
      prev_acc = 1'b1;
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_write: got %h expected none", cur);
      end else begin
        e = exp_q.pop_front();
        check("write_txn", cur, e);
      end
    end
    prev_we   = DDRAM_WE;
    prev_busy = DDRAM_BUSY;
    prev_rst  = reset;
    prev_out  = cur;
  end

  // Reference model: a qword buffer of lanes; qword address = 0x6000000 + byte_addr/8.
  function automatic void m_push();
    exp_q.push_back({29'h6000000 + 29'(m_qaddr), m_data, m_be});
    m_be   = 8'h00;
    m_data = 64'h0;
  endfunction

  function automatic void model_req(input logic [24:0] a, input logic [15:0] d, input bit fl,
                                    output bit mism, output bit full);
    logic [21:0] qa;
    int lane;
    qa   = a[24:3];
    lane = int'(a[2:1]);
    mism = (m_be != 8'h00) && (m_qaddr != qa);
    if (mism) m_push();
    m_qaddr = qa;
    m_data[lane*16 +: 16] = d;
    m_be[lane*2 +: 2] = 2'b11;
    full = (m_be == 8'hFF);
    if (full || (fl && !mism)) m_push();
  endfunction

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic drive_req(input logic [24:0] a, input logic [15:0] d, input bit fl);
    wraddr = a;
    din    = d;
    we_req = ~we_req;
    flush  = fl;
    step();
    flush  = 1'b0;
  endtask

  task automatic wait_ack();
    for (int i = 0; i < 200 && we_ack != we_req; i++) step();
    check("ack_timeout", we_ack == we_req, 1'b1);
  endtask

  task automatic settle();
    repeat (2) step();
    for (int i = 0; i < 200 && (state_dbg || DDRAM_WE); i++) step();
    check("settle_timeout", {state_dbg, DDRAM_WE}, 2'b00);
    check("idle_vs_model", idle, m_be == 8'h00);
    check("be_vs_model", DDRAM_BE, m_be);
    if (m_be != 8'h00) check("addr_vs_model", DDRAM_ADDR, 29'h6000000 + 29'(m_qaddr));
  endtask

  task automatic do_req(input logic [24:0] a, input logic [15:0] d, input bit fl);
    bit mism, full;
    model_req(a, d, fl, mism, full);
    drive_req(a, d, fl);
    if (mism) begin
      check("mismatch_no_early_ack", we_ack != we_req, 1'b1);
      check("mismatch_we", DDRAM_WE, 1'b1);
      wait_ack();
    end else begin
      check("ack_latency", we_ack == we_req, 1'b1);
      if (full) begin
        step();
        check("full_we_latency", DDRAM_WE, 1'b1);
      end
    end
    settle();
  endtask

  task automatic do_flush();
    if (m_be != 8'h00) m_push();
    flush = 1'b1;
    step();
    flush = 1'b0;
    settle();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit mism, full;
    logic [21:0] qs;
    logic [24:0] a;

    // Reset state
    repeat (3) step();
    reset = 1'b0;
    check("rst_idle", idle, 1'b1);
    check("rst_addr", DDRAM_ADDR, 29'h6000000);
    check("rst_din", DDRAM_DIN, 64'h0);
    check("rst_be", DDRAM_BE, 8'h00);
    check("rst_we", DDRAM_WE, 1'b0);
    check("rst_ack", we_ack, we_req);
    check("burstcnt", DDRAM_BURSTCNT, 8'd1);
    check("rd", DDRAM_RD, 1'b0);

    // Full qword from four lanes
    do_req(25'h000, 16'h1111, 1'b0);
    do_req(25'h002, 16'h2222, 1'b0);
    do_req(25'h004, 16'h3333, 1'b0);
    do_req(25'h006, 16'h4444, 1'b0);

    // Single lane then flush
    do_req(25'h00A, 16'hBEEF, 1'b0);
    do_flush();

    // Address change forces the partial write before the new request is acked
    do_req(25'h000, 16'h0123, 1'b0);
    do_req(25'h008, 16'h4567, 1'b0);
    do_flush();

    // Lane overwrite
    do_req(25'h002, 16'hAAAA, 1'b0);
    do_req(25'h002, 16'h5555, 1'b0);
    do_flush();

    // Flush with nothing buffered, and flush coinciding with a request
    do_flush();
    do_req(25'h018, 16'hC0DE, 1'b1);

    // Long BUSY on a full qword, with a request arriving during the write
    busy_mode = 2;
    do_req(25'h040, 16'hA0A0, 1'b0);
    do_req(25'h042, 16'hB1B1, 1'b0);
    do_req(25'h044, 16'hC2C2, 1'b0);
    model_req(25'h046, 16'hD3D3, 1'b0, mism, full);
    drive_req(25'h046, 16'hD3D3, 1'b0);
    check("busy_ack4", we_ack == we_req, 1'b1);
    step();
    check("busy_we_up", DDRAM_WE, 1'b1);
    model_req(25'h050, 16'h5A5A, 1'b0, mism, full);
    drive_req(25'h050, 16'h5A5A, 1'b0);
    repeat (4) step();
    check("no_ack_during_write", we_ack != we_req, 1'b1);
    busy_mode = 0;
    wait_ack();
    settle();
    do_flush();

    // Randomized traffic with random BUSY
    busy_mode = 1;
    for (int it = 0; it < 80; it++) begin
      if ($urandom_range(0, 5) == 0) begin
        do_flush();
      end else begin
        case ($urandom_range(0, 2))
          0:       qs = 22'h000000;
          1:       qs = 22'h000001;
          default: qs = 22'h3FFFFF;
        endcase
        a = {qs, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1))};
        do_req(a, 16'($urandom), $urandom_range(0, 4) == 0);
      end
    end
    busy_mode = 0;
    do_flush();

    // Reset in the middle of a stalled write with a request pending
    busy_mode = 2;
    do_req(25'h020, 16'h1010, 1'b0);
    do_req(25'h022, 16'h2020, 1'b0);
    do_req(25'h024, 16'h3030, 1'b0);
    model_req(25'h026, 16'h4040, 1'b0, mism, full);
    drive_req(25'h026, 16'h4040, 1'b0);
    step();
    check("rst_mid_we_up", DDRAM_WE, 1'b1);
    drive_req(25'h030, 16'h7777, 1'b0);
    reset = 1'b1;
    exp_q.delete();
    m_be   = 8'h00;
    m_data = 64'h0;
    step();
    reset = 1'b0;
    check("rst_mid_we", DDRAM_WE, 1'b0);
    check("rst_mid_ack", we_ack == we_req, 1'b1);
    check("rst_mid_idle", idle, 1'b1);
    check("rst_mid_be", DDRAM_BE, 8'h00);
    check("rst_mid_din", DDRAM_DIN, 64'h0);
    busy_mode = 0;
    repeat (10) step();
    check("rst_mid_quiet", {DDRAM_WE, idle}, 2'b01);

    check("exp_q_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
